// File: rtl/npc_pkg.sv
// Shared types and helpers for the next-PC generator: FSM state encoding,
// default widths, and the sign-extend-and-add used for relative targets.
package npc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   localparam int unsigned D_DEF     = 12;
   localparam int unsigned OFF_W_DEF = 8;
   localparam int unsigned LUT_A_DEF = 5;

   // Operands arrive zero-extended to 32 bits; the caller keeps the low D bits,
   // which gives the modulo 2**D wrap for free.
   function automatic logic [31:0] sext_add(input logic [31:0] base,
                                            input logic [31:0] off,
                                            input int unsigned off_w);
      logic        [31:0] shifted;
      logic signed [31:0] ext;
      shifted = off << (32 - off_w);
      ext     = $signed(shifted) >>> (32 - off_w);
      return base + $unsigned(ext);
   endfunction

endpackage

// File: rtl/next_pc_unit_jump_lut.sv
// Writable jump table: synchronous write, combinational read, cleared on reset.
// A read of the address being written this cycle sees the old contents.
module jump_lut #(
   parameter int unsigned D     = 12,
   parameter int unsigned LUT_A = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             we,
   input  logic [LUT_A-1:0] waddr,
   input  logic [D-1:0]     wdata,
   input  logic [LUT_A-1:0] raddr,
   output logic [D-1:0]     rdata
);

   logic [D-1:0] mem [2**LUT_A];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 2**LUT_A; i++) mem[i] <= '0;
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/next_pc_unit.sv
// Next-PC generator: run/halt FSM, combinational target select, jump table,
// and an optional return-address stack compiled in with NPC_RAS_EN.
//
// state   | meaning
// ST_IDLE | after reset, target = 0, waiting for start
// ST_RUN  | fetching; target chosen by halt/stall/ret/branch/increment priority
// ST_HALT | stopped, target holds prog_ctr until start
module next_pc_unit
   import npc_pkg::*;
#(
   parameter int unsigned D         = D_DEF,
   parameter int unsigned OFF_W     = OFF_W_DEF,
   parameter int unsigned LUT_A     = LUT_A_DEF,
   parameter int unsigned RAS_DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [D-1:0]     prog_ctr,
   input  logic             branch_en,
   input  logic             take,
   input  logic             jump_abs,
   input  logic [LUT_A-1:0] lut_idx,
   input  logic [OFF_W-1:0] rel_off,
   input  logic             call,
   input  logic             ret,
   input  logic             stall,
   input  logic             halt_req,
   input  logic             lut_we,
   input  logic [LUT_A-1:0] lut_waddr,
   input  logic [D-1:0]     lut_wdata,
   output logic [D-1:0]     target,
   output logic             running,
   output logic             done,
   output logic             ras_err
);

   state_t       state;
   logic [D-1:0] lut_rdata;
   logic [D-1:0] pc_inc;
   logic [D-1:0] pc_rel;
   logic [D-1:0] ret_target;
   logic [31:0]  rel_full;
   logic         taken;
   logic         unused_bits;

   assign taken    = branch_en & take;
   assign pc_inc   = prog_ctr + D'(1);
   assign rel_full = sext_add({{(32-D){1'b0}}, prog_ctr},
                              {{(32-OFF_W){1'b0}}, rel_off}, OFF_W);
   assign pc_rel   = rel_full[D-1:0];

   jump_lut #(.D(D), .LUT_A(LUT_A)) u_lut (
      .clk   (clk),
      .reset (reset),
      .we    (lut_we),
      .waddr (lut_waddr),
      .wdata (lut_wdata),
      .raddr (lut_idx),
      .rdata (lut_rdata)
   );

`ifdef NPC_RAS_EN
   localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

   logic [D-1:0]  ras_mem [RAS_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] top_ptr;
   logic [CW-1:0] count;
   logic          ras_empty;
   logic          run_free;
   logic          do_push;
   logic          do_pop;
   logic          underflow;
   logic          err_q;

   // wr_ptr is the next free slot; the stack wraps and overwrites the oldest.
   assign top_ptr   = (wr_ptr == '0) ? PW'(RAS_DEPTH - 1) : wr_ptr - PW'(1);
   assign ras_empty = (count == '0);
   assign run_free  = (state == ST_RUN) & ~halt_req & ~stall;
   assign do_pop    = run_free & ret & ~ras_empty;
   assign underflow = run_free & ret & ras_empty;
   assign do_push   = run_free & ~ret & taken & call;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         count  <= '0;
         err_q  <= 1'b0;
         for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
      end else begin
         if (do_push) begin
            ras_mem[wr_ptr] <= pc_inc;
            wr_ptr <= (wr_ptr == PW'(RAS_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            if (count != CW'(RAS_DEPTH)) count <= count + CW'(1);
         end else if (do_pop) begin
            wr_ptr <= top_ptr;
            count  <= count - CW'(1);
         end
         if (underflow) err_q <= 1'b1;
      end
   end

   assign ret_target  = ras_empty ? pc_inc : ras_mem[top_ptr];
   assign ras_err     = err_q;
   assign unused_bits = ^rel_full[31:D];
`else
   assign ret_target  = pc_inc;
   assign ras_err     = 1'b0;
   assign unused_bits = ^rel_full[31:D] ^ call ^ (RAS_DEPTH == 0);
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: if (start)    state <= ST_RUN;
            ST_RUN:  if (halt_req) state <= ST_HALT;
            ST_HALT: if (start)    state <= ST_RUN;
            default:               state <= ST_IDLE;
         endcase
      end
   end

   assign running = (state == ST_RUN);
   assign done    = (state == ST_HALT);

   always_comb begin
      target = '0;
      case (state)
         ST_RUN: begin
            if (halt_req)   target = prog_ctr;
            else if (stall) target = prog_ctr;
            else if (ret)   target = ret_target;
            else if (taken) target = jump_abs ? lut_rdata : pc_rel;
            else            target = pc_inc;
         end
         ST_HALT: target = prog_ctr;
         default: target = '0;
      endcase
   end

endmodule

// File: tb/tb_next_pc_unit.sv
// Self-checking bench for next_pc_unit: vector table for RUN-state target
// selection plus hand sequences for jump table, halt/start, RAS and reset.
module tb_next_pc_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start, branch_en, take, jump_abs, call, ret, stall, halt_req, lut_we;
   logic [11:0] prog_ctr, lut_wdata, target;
   logic [4:0]  lut_idx, lut_waddr;
   logic [7:0]  rel_off;
   logic        running, done, ras_err;

`ifdef NPC_RAS_EN
   localparam logic RAS = 1'b1;
`else
   localparam logic RAS = 1'b0;
`endif

   next_pc_unit dut (
      .clk(clk), .reset(reset), .start(start), .prog_ctr(prog_ctr),
      .branch_en(branch_en), .take(take), .jump_abs(jump_abs), .lut_idx(lut_idx),
      .rel_off(rel_off), .call(call), .ret(ret), .stall(stall), .halt_req(halt_req),
      .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
      .target(target), .running(running), .done(done), .ras_err(ras_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [11:0] target;
      logic        running;
      logic        done;
      logic        ras_err;
   } exp_t;

   typedef struct packed {
      logic [11:0] pc;
      logic        be;
      logic        tk;
      logic        ja;
      logic [4:0]  idx;
      logic [7:0]  off;
      logic        cl;
      logic        st;
      logic [11:0] exp;
   } vec_t;

   exp_t  exp_q[$];
   string name_q[$];
   vec_t  vecs[8];
   int    checks = 0;
   int    failures = 0;
   logic [11:0] pc_model;

   task automatic clr();
      start = 1'b0; branch_en = 1'b0; take = 1'b0; jump_abs = 1'b0;
      call = 1'b0; ret = 1'b0; stall = 1'b0; halt_req = 1'b0; lut_we = 1'b0;
      lut_idx = '0; lut_waddr = '0; lut_wdata = '0; rel_off = '0;
   endtask

   // Push the expectation, sample at the falling edge, then advance one cycle.
   task automatic step(input string name, input logic [11:0] t,
                       input logic r, input logic d, input logic e);
      exp_t  ex;
      string nm;
      exp_q.push_back('{t, r, d, e});
      name_q.push_back(name);
      @(negedge clk);
      ex = exp_q.pop_front();
      nm = name_q.pop_front();
      checks++;
      if ({target, running, done, ras_err} !== ex) begin
         failures++;
         $display("FAIL %s: got target=%h running=%b done=%b ras_err=%b, want target=%h running=%b done=%b ras_err=%b",
                  nm, target, running, done, ras_err, ex.target, ex.running, ex.done, ex.ras_err);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{12'h010, 1'b1, 1'b1, 1'b0, 5'd0, 8'hF8, 1'b0, 1'b0, 12'h008};
      vecs[1] = '{12'hFFF, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 12'h000};
      vecs[2] = '{12'h100, 1'b1, 1'b1, 1'b0, 5'd0, 8'h7F, 1'b0, 1'b0, 12'h17F};
      vecs[3] = '{12'h100, 1'b1, 1'b0, 1'b0, 5'd0, 8'h40, 1'b0, 1'b0, 12'h101};
      vecs[4] = '{12'h020, 1'b0, 1'b1, 1'b0, 5'd0, 8'h40, 1'b0, 1'b0, 12'h021};
      vecs[5] = '{12'h005, 1'b1, 1'b1, 1'b0, 5'd0, 8'h40, 1'b0, 1'b1, 12'h005};
      vecs[6] = '{12'h000, 1'b1, 1'b1, 1'b0, 5'd0, 8'h80, 1'b0, 1'b0, 12'hF80};
      vecs[7] = '{12'h050, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 1'b0, 12'h051};

      clr();
      prog_ctr = 12'h055;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      step("reset_hold", 12'h000, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      step("idle", 12'h000, 1'b0, 1'b0, 1'b0);
      start = 1'b1;
      prog_ctr = 12'h000;
      step("idle_start", 12'h000, 1'b0, 1'b0, 1'b0);
      start = 1'b0;

      pc_model = 12'h000;
      for (int i = 0; i < 3; i++) begin
         prog_ctr = pc_model;
         step("seq_inc", 12'(i + 1), 1'b1, 1'b0, 1'b0);
         pc_model = 12'(i + 1);
      end

      for (int i = 0; i < 8; i++) begin
         clr();
         prog_ctr  = vecs[i].pc;
         branch_en = vecs[i].be;
         take      = vecs[i].tk;
         jump_abs  = vecs[i].ja;
         lut_idx   = vecs[i].idx;
         rel_off   = vecs[i].off;
         call      = vecs[i].cl;
         stall     = vecs[i].st;
         step($sformatf("vec%0d", i), vecs[i].exp, 1'b1, 1'b0, 1'b0);
      end

      clr();
      prog_ctr = 12'h005; branch_en = 1'b1; take = 1'b1; jump_abs = 1'b1; lut_idx = 5'd3;
      lut_we = 1'b1; lut_waddr = 5'd3; lut_wdata = 12'h2A0;
      step("lut_same_cycle_old", 12'h000, 1'b1, 1'b0, 1'b0);
      lut_we = 1'b0;
      step("lut_abs_jump", 12'h2A0, 1'b1, 1'b0, 1'b0);
      lut_idx = 5'd31; lut_we = 1'b1; lut_waddr = 5'd31; lut_wdata = 12'hABC;
      step("lut31_old", 12'h000, 1'b1, 1'b0, 1'b0);
      lut_idx = 5'd31; lut_waddr = 5'd1; lut_wdata = 12'h100;
      step("lut31_new", 12'hABC, 1'b1, 1'b0, 1'b0);
      lut_we = 1'b0; lut_idx = 5'd4;
      step("lut4_zero", 12'h000, 1'b1, 1'b0, 1'b0);

      clr();
      prog_ctr = 12'h077; halt_req = 1'b1; start = 1'b1;
      step("halt_wins", 12'h077, 1'b1, 1'b0, 1'b0);
      clr();
      prog_ctr = 12'h077; ret = 1'b1; stall = 1'b1; branch_en = 1'b1; take = 1'b1; call = 1'b1;
      step("halt_hold", 12'h077, 1'b0, 1'b1, 1'b0);
      clr();
      prog_ctr = 12'h077; start = 1'b1;
      step("halt_start", 12'h077, 1'b0, 1'b1, 1'b0);
      start = 1'b0;
      step("restart_run", 12'h078, 1'b1, 1'b0, 1'b0);

`ifdef NPC_RAS_EN
      clr();
      prog_ctr = 12'h040; branch_en = 1'b1; take = 1'b1; jump_abs = 1'b1; lut_idx = 5'd1; call = 1'b1;
      step("call_abs", 12'h100, 1'b1, 1'b0, 1'b0);
      clr();
      prog_ctr = 12'h105; ret = 1'b1;
      step("ret", 12'h041, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         clr();
         prog_ctr = 12'(12'h200 + i); branch_en = 1'b1; take = 1'b1; rel_off = 8'h10; call = 1'b1;
         step("nest_call", 12'(12'h210 + i), 1'b1, 1'b0, 1'b0);
      end
      for (int i = 0; i < 4; i++) begin
         clr();
         prog_ctr = 12'h300; ret = 1'b1;
         step("nest_ret", 12'(12'h205 - i), 1'b1, 1'b0, 1'b0);
      end
      clr();
      prog_ctr = 12'h300; ret = 1'b1;
      step("ret_underflow", 12'h301, 1'b1, 1'b0, 1'b0);
      clr();
      prog_ctr = 12'h301;
      step("ras_err_set", 12'h302, 1'b1, 1'b0, 1'b1);
      clr();
      prog_ctr = 12'h060; branch_en = 1'b1; take = 1'b1; rel_off = 8'h10; call = 1'b1;
      step("call2", 12'h070, 1'b1, 1'b0, 1'b1);
      clr();
      prog_ctr = 12'h070; ret = 1'b1; call = 1'b1; branch_en = 1'b1; take = 1'b1; rel_off = 8'h10;
      step("call_ret_same", 12'h061, 1'b1, 1'b0, 1'b1);
      clr();
      prog_ctr = 12'h090; ret = 1'b1;
      step("no_push_on_ret", 12'h091, 1'b1, 1'b0, 1'b1);
`else
      clr();
      prog_ctr = 12'h033; ret = 1'b1; branch_en = 1'b1; take = 1'b1; rel_off = 8'h10;
      step("ret_as_inc", 12'h034, 1'b1, 1'b0, 1'b0);
      clr();
      prog_ctr = 12'h040; branch_en = 1'b1; take = 1'b1; rel_off = 8'h10; call = 1'b1;
      step("call_as_branch", 12'h050, 1'b1, 1'b0, 1'b0);
      clr();
      prog_ctr = 12'h050;
      step("ras_err_zero", 12'h051, 1'b1, 1'b0, 1'b0);
`endif

      clr();
      prog_ctr = 12'h010; branch_en = 1'b1; take = 1'b1; rel_off = 8'h08; call = 1'b1;
      step("pre_call", 12'h018, 1'b1, 1'b0, RAS);
      clr();
      prog_ctr = 12'h018; halt_req = 1'b1;
      step("halt2", 12'h018, 1'b1, 1'b0, RAS);
      clr();
      reset = 1'b1;
      step("reset_in_halt", 12'h018, 1'b0, 1'b1, RAS);
      reset = 1'b0;
      step("after_reset", 12'h000, 1'b0, 1'b0, 1'b0);
      start = 1'b1;
      step("start2", 12'h000, 1'b0, 1'b0, 1'b0);
      clr();
      prog_ctr = 12'h123; ret = 1'b1;
      step("ret_after_reset", 12'h124, 1'b1, 1'b0, 1'b0);
      clr();
      prog_ctr = 12'h124;
      step("err_after_reset", 12'h125, 1'b1, 1'b0, RAS);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/next_pc_unit.md
# next_pc_unit

Next-PC generator for the fetch path. Each cycle it computes the `target` value that the program counter register loads on the following edge: sequential increment, relative branch, absolute jump through a writable jump table, stall hold, or halt. It owns the run/halt state machine and, optionally, a return-address stack for call/return. It consumes `prog_ctr` from the PC and drives its `target` input.

## Interface
- `D`, 12, PC width in bits
- `OFF_W`, 8, signed relative-offset width
- `LUT_A`, 5, jump-table address width (2**LUT_A entries of D bits)
- `RAS_DEPTH`, 4, return-address stack entries (used only with RAS compiled in)

- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `start`  in  1  single-cycle pulse: leave IDLE/HALT, begin fetching from the current `prog_ctr`
- `prog_ctr`  in  D  current PC value
- `branch_en`  in  1  current instruction is a branch or jump
- `take`  in  1  branch condition true (ignored unless `branch_en`)
- `jump_abs`  in  1  1 = absolute via table, 0 = relative offset
- `lut_idx`  in  LUT_A  jump-table index
- `rel_off`  in  OFF_W  signed PC-relative offset
- `call`  in  1  taken branch that also pushes a return address
- `ret`  in  1  return: pop the return address
- `stall`  in  1  hold the PC
- `halt_req`  in  1  stop execution
- `lut_we`  in  1  jump-table write enable
- `lut_waddr`  in  LUT_A  jump-table write address
- `lut_wdata`  in  D  jump-table write data
- `target`  out  D  next PC value
- `running`  out  1  state == RUN
- `done`  out  1  state == HALT
- `ras_err`  out  1  sticky: RAS underflow has occurred

## Operation
- States: IDLE, RUN, HALT. Reset → IDLE.
- IDLE: `target`=0. On `start` → RUN.
- RUN. `target` is combinational; priority is highest first:
  1. `halt_req`: `target`=`prog_ctr`, next state HALT.
  2. `stall`: `target`=`prog_ctr`.
  3. `ret`: `target`=top of RAS, then pop.
  4. `branch_en & take`: if `jump_abs`, `target`=lut[`lut_idx`]; otherwise `target`=`prog_ctr`+sign-extended `rel_off`. If `call` is also high, push `prog_ctr`+1.
  5. Otherwise `target`=`prog_ctr`+1.
- HALT: `target`=`prog_ctr`. `start` → RUN. `done` stays high until then.
- All arithmetic is modulo 2**D, so increment and relative targets wrap silently (`prog_ctr`=0xFFF with +1 gives 0x000).
- Jump table:
  - Registered array, all entries cleared on reset.
  - A write takes effect on the next edge.
  - A same-cycle read of the address being written returns the old value.
- `call` without `branch_en & take` is ignored.
- `stall`, `ret` and `call` are ignored outside RUN.

## Timing
- Reset values: `target`=0, `running`=0, `done`=0, `ras_err`=0, RAS empty, table all zero.
- Zero-cycle latency from inputs to `target`. The PC register adds one edge.
- A `start` edge gives `running`=1 in the next cycle. `halt_req` in cycle n gives `done`=1 in cycle n+1.
- `reset` has priority over everything, including mid-call and while in HALT.
- `start` and `halt_req` in the same RUN cycle: halt wins.

## Configuration
- `NPC_RAS_EN` defined:
  - A RAS of `RAS_DEPTH` entries implements `call` and `ret`.
  - Push when full overwrites the oldest entry (circular).
  - `ret` when empty gives `target`=`prog_ctr`+1 and sets `ras_err` until reset.
  - `call` and `ret` in the same cycle: `ret` wins and no push occurs.
- `NPC_RAS_EN` undefined:
  - No RAS storage.
  - `call` behaves as a plain branch.
  - `ret` behaves as increment.
  - `ras_err` is tied to 0.

## Structure
- Package `npc_pkg`: state enum (IDLE/RUN/HALT), default `D`/`OFF_W`/`LUT_A` constants, and the function for sign-extend-and-add modulo 2**D.
- Sub-module `jump_lut`: the writable table with synchronous write, combinational read, and reset clear.
- The RAS stays inline, inside the `NPC_RAS_EN` guard.

## Test plan
- Reset, then `start`, then 3 idle RUN cycles with `prog_ctr` fed back from `target` → `target` sequence 1, 2, 3; `running`=1.
- `prog_ctr`=0x010, `branch_en`=`take`=1, `jump_abs`=0, `rel_off`=0xF8 → `target`=0x008. At `prog_ctr`=0xFFF with no branch → `target`=0x000.
- Write lut[3]=0x2A0, then next cycle at `prog_ctr`=0x005 do an absolute jump with `lut_idx`=3 → `target`=0x2A0. A same-cycle write-and-read of lut[3] returns the old value.
- `stall` with `branch_en`=`take`=1 → `target`=`prog_ctr`. `halt_req` → `done`=1 next cycle and `target` holds. `start` → `running`=1.
- `NPC_RAS_EN`: `call` at 0x040 to 0x100, then `ret` at 0x105 → `target`=0x041. Five nested calls with `RAS_DEPTH`=4 then five `ret`s → first four pop correctly, fifth sets `ras_err`=1 and gives `target`=`prog_ctr`+1.
- Assert `reset` while in HALT with a non-empty RAS → next cycle all outputs are at reset values and the state is IDLE.
